// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes ALUOp/funct, runs single-cycle ops and a shift-add multiplier.
// Latency: 1 cycle for add/sub/and/or/slt/illegal, DATA_W cycles for mul.
// Backpressure: ready_o low while a multiply iterates; no output backpressure.
module alu_exec_unit #(
   parameter int DATA_W = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic              kill_i,
   input  logic [1:0]        ALUOp_i,
   input  logic [5:0]        funct_i,
   input  logic [DATA_W-1:0] data1_i,
   input  logic [DATA_W-1:0] data2_i,
   output logic              ready_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              zero_o,
   output logic              illegal_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   // R-type function codes
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_MUL = 6'b011000;

   typedef enum logic [2:0] {
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_SLT,
      OP_MUL,
      OP_ILL
   } op_e;

   typedef enum logic {
      ST_IDLE,
      ST_MUL
   } state_e;

   state_e            state;
   op_e               op;
   logic [DATA_W-1:0] sc_res;
   logic              slt_lt;

   // multiplier datapath
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] acc_nxt;
   logic [CNT_W-1:0]  cnt;

   // Decode ALUOp/funct into an internal operation; mul is illegal when not built in
   always_comb begin
      op = OP_ILL;
      case (ALUOp_i)
         2'b00: op = OP_ADD;
         2'b01: op = OP_SUB;
         2'b11: op = OP_OR;
         default: begin
            case (funct_i)
               FUNCT_ADD: op = OP_ADD;
               FUNCT_SUB: op = OP_SUB;
               FUNCT_AND: op = OP_AND;
               FUNCT_OR:  op = OP_OR;
               FUNCT_SLT: op = OP_SLT;
               FUNCT_MUL: op = MUL_EN ? OP_MUL : OP_ILL;
               default:   op = OP_ILL;
            endcase
         end
      endcase
   end

   // Single-cycle result; illegal (and mul, which is not taken from here) yield zero
   always_comb begin
      sc_res = '0;
      slt_lt = ($signed(data1_i) < $signed(data2_i));
      case (op)
         OP_ADD:  sc_res = data1_i + data2_i;
         OP_SUB:  sc_res = data1_i - data2_i;
         OP_AND:  sc_res = data1_i & data2_i;
         OP_OR:   sc_res = data1_i | data2_i;
         OP_SLT:  sc_res = {{(DATA_W-1){1'b0}}, slt_lt};
         default: sc_res = '0;
      endcase
   end

   // One shift-add step: conditionally add the shifted multiplicand
   always_comb begin
      acc_nxt = acc + (mplier[0] ? mcand : '0);
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         ready_o   <= 1'b1;
         valid_o   <= 1'b0;
         illegal_o <= 1'b0;
         data_o    <= '0;
         zero_o    <= 1'b1;
         cnt       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
      end else begin
         valid_o   <= 1'b0;
         illegal_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (valid_i) begin
                  if (op == OP_MUL) begin
                     mcand   <= data1_i;
                     mplier  <= data2_i;
                     acc     <= '0;
                     cnt     <= CNT_W'(DATA_W);
                     state   <= ST_MUL;
                     ready_o <= 1'b0;
                  end else begin
                     data_o    <= sc_res;
                     zero_o    <= (sc_res == '0);
                     valid_o   <= 1'b1;
                     illegal_o <= (op == OP_ILL);
                  end
               end
            end
            ST_MUL: begin
               if (kill_i) begin
                  // abort: drop the partial product, keep the previous result visible
                  state   <= ST_IDLE;
                  ready_o <= 1'b1;
                  cnt     <= '0;
               end else begin
                  acc    <= acc_nxt;
                  mcand  <= {mcand[DATA_W-2:0], 1'b0};
                  mplier <= {1'b0, mplier[DATA_W-1:1]};
                  cnt    <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     state   <= ST_IDLE;
                     ready_o <= 1'b1;
                     data_o  <= acc_nxt;
                     zero_o  <= (acc_nxt == '0);
                     valid_o <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= ST_IDLE;
               ready_o <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        kill_i;
   logic [1:0]  aluop;
   logic [5:0]  funct;
   logic [31:0] d1;
   logic [31:0] d2;

   logic        ready1, valid1, zero1, ill1;
   logic [31:0] data1;
   logic        ready2, valid2, zero2, ill2;
   logic [31:0] data2;

   int tests = 0;
   int fails = 0;
   int vcount = 0;
   int vsnap;
   int lowcnt;
   logic dut2_ready_dropped = 1'b0;

   always #5 clk = ~clk;

   alu_exec_unit #(.DATA_W(32), .MUL_EN(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .kill_i(kill_i),
      .ALUOp_i(aluop), .funct_i(funct), .data1_i(d1), .data2_i(d2),
      .ready_o(ready1), .valid_o(valid1), .data_o(data1), .zero_o(zero1),
      .illegal_o(ill1)
   );

   alu_exec_unit #(.DATA_W(32), .MUL_EN(1'b0)) dut_nomul (
      .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .kill_i(kill_i),
      .ALUOp_i(aluop), .funct_i(funct), .data1_i(d1), .data2_i(d2),
      .ready_o(ready2), .valid_o(valid2), .data_o(data2), .zero_o(zero2),
      .illegal_o(ill2)
   );

   always @(negedge clk) begin
      if (valid1 === 1'b1) vcount++;
      if (ready2 !== 1'b1) dut2_ready_dropped = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b);
      valid_i = v;
      aluop   = op;
      funct   = f;
      d1      = a;
      d2      = b;
   endtask

   // issue a mul at a negedge, return at the negedge where ready_o is back high
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, output int low);
      drive(1'b1, 2'b10, 6'b011000, a, b);
      @(negedge clk);
      valid_i = 1'b0;
      low = 0;
      while (ready1 !== 1'b1 && low < 40) begin
         low++;
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1;
      kill_i = 1'b0;
      drive(1'b0, 2'b00, 6'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("rst_ready", {31'b0, ready1}, 32'd1);
      check("rst_valid", {31'b0, valid1}, 32'd0);
      check("rst_illegal", {31'b0, ill1}, 32'd0);
      check("rst_data", data1, 32'h0);
      check("rst_zero", {31'b0, zero1}, 32'd1);

      // reset in the middle of a multiply
      rst = 1'b0;
      drive(1'b1, 2'b10, 6'b011000, 32'd9, 32'd9);
      @(negedge clk);
      valid_i = 1'b0;
      check("mul_started_ready", {31'b0, ready1}, 32'd0);
      repeat (4) @(negedge clk);
      vsnap = vcount;
      rst = 1'b1;
      #1;
      check("midrst_ready", {31'b0, ready1}, 32'd1);
      check("midrst_valid", {31'b0, valid1}, 32'd0);
      check("midrst_data", data1, 32'h0);
      check("midrst_zero", {31'b0, zero1}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("midrst_no_valid", vcount, vsnap);
      drive(1'b1, 2'b00, 6'b0, 32'd2, 32'd3);
      @(negedge clk);
      check("post_rst_add_valid", {31'b0, valid1}, 32'd1);
      check("post_rst_add_data", data1, 32'd5);
      check("post_rst_add_zero", {31'b0, zero1}, 32'd0);

      // back-to-back single-cycle ops
      drive(1'b1, 2'b00, 6'b0, 32'hFFFF_FFFF, 32'd1);
      @(negedge clk);
      check("add_wrap_valid", {31'b0, valid1}, 32'd1);
      check("add_wrap_data", data1, 32'h0);
      check("add_wrap_zero", {31'b0, zero1}, 32'd1);
      drive(1'b1, 2'b01, 6'b0, 32'd5, 32'd7);
      @(negedge clk);
      check("sub_valid", {31'b0, valid1}, 32'd1);
      check("sub_data", data1, 32'hFFFF_FFFE);
      check("sub_zero", {31'b0, zero1}, 32'd0);
      drive(1'b1, 2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00);
      @(negedge clk);
      check("and_valid", {31'b0, valid1}, 32'd1);
      check("and_data", data1, 32'h0000_F000);
      drive(1'b1, 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
      @(negedge clk);
      check("slt_data", data1, 32'd1);
      drive(1'b1, 2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF);
      @(negedge clk);
      check("slt_false_data", data1, 32'd0);
      drive(1'b1, 2'b11, 6'b0, 32'h0000_000F, 32'h0000_00F0);
      @(negedge clk);
      check("or_op11_data", data1, 32'h0000_00FF);
      drive(1'b1, 2'b10, 6'b100101, 32'hA000_0000, 32'h0000_0005);
      @(negedge clk);
      check("or_funct_data", data1, 32'hA000_0005);
      drive(1'b1, 2'b10, 6'b100010, 32'd100, 32'd1);
      @(negedge clk);
      check("sub_funct_data", data1, 32'd99);
      drive(1'b0, 2'b00, 6'b0, 32'd0, 32'd0);
      @(negedge clk);
      check("single_pulse", {31'b0, valid1}, 32'd0);
      check("data_hold", data1, 32'd99);

      // multiply 7 x 6, then an add in the valid_o cycle
      do_mul(32'd7, 32'd6, lowcnt);
      check("mul_ready_low_cycles", lowcnt, 32'd32);
      check("mul_valid", {31'b0, valid1}, 32'd1);
      check("mul_data", data1, 32'd42);
      check("mul_illegal", {31'b0, ill1}, 32'd0);
      drive(1'b1, 2'b00, 6'b0, 32'd10, 32'd20);
      @(negedge clk);
      check("b2b_add_valid", {31'b0, valid1}, 32'd1);
      check("b2b_add_data", data1, 32'd30);
      valid_i = 1'b0;

      do_mul(32'hFFFF_FFFF, 32'd2, lowcnt);
      check("mul2_ready_low_cycles", lowcnt, 32'd32);
      check("mul2_valid", {31'b0, valid1}, 32'd1);
      check("mul2_data", data1, 32'hFFFF_FFFE);

      do_mul(32'h0001_0003, 32'h0000_1005, lowcnt);
      check("mul3_data", data1, 32'h1005_300F);

      // kill ten cycles into a multiply
      drive(1'b1, 2'b10, 6'b011000, 32'd3, 32'd5);
      @(negedge clk);
      valid_i = 1'b0;
      repeat (9) @(negedge clk);
      vsnap = vcount;
      kill_i = 1'b1;
      @(negedge clk);
      kill_i = 1'b0;
      check("kill10_ready", {31'b0, ready1}, 32'd1);
      check("kill10_valid", {31'b0, valid1}, 32'd0);
      check("kill10_data", data1, 32'h1005_300F);
      repeat (40) @(negedge clk);
      check("kill10_no_valid", vcount, vsnap);

      // kill on the final iteration edge
      drive(1'b1, 2'b10, 6'b011000, 32'd3, 32'd5);
      @(negedge clk);
      valid_i = 1'b0;
      repeat (31) @(negedge clk);
      check("killlast_still_busy", {31'b0, ready1}, 32'd0);
      vsnap = vcount;
      kill_i = 1'b1;
      @(negedge clk);
      kill_i = 1'b0;
      check("killlast_ready", {31'b0, ready1}, 32'd1);
      check("killlast_valid", {31'b0, valid1}, 32'd0);
      check("killlast_data", data1, 32'h1005_300F);
      repeat (5) @(negedge clk);
      check("killlast_no_valid", vcount, vsnap);

      // kill in IDLE does not block an accept
      kill_i = 1'b1;
      drive(1'b1, 2'b00, 6'b0, 32'd1, 32'd1);
      @(negedge clk);
      kill_i = 1'b0;
      check("idle_kill_valid", {31'b0, valid1}, 32'd1);
      check("idle_kill_data", data1, 32'd2);

      // illegal funct
      drive(1'b1, 2'b10, 6'b111111, 32'd5, 32'd6);
      @(negedge clk);
      check("ill_valid", {31'b0, valid1}, 32'd1);
      check("ill_flag", {31'b0, ill1}, 32'd1);
      check("ill_data", data1, 32'h0);
      check("ill_zero", {31'b0, zero1}, 32'd1);
      drive(1'b0, 2'b00, 6'b0, 32'd0, 32'd0);
      @(negedge clk);
      check("ill_pulse", {31'b0, ill1}, 32'd0);

      // mul on the MUL_EN=0 build is illegal; the MUL_EN=1 build multiplies
      do_mul(32'd7, 32'd6, lowcnt);
      check("nomul_data_after", data2, 32'h0);
      check("mulen_data", data1, 32'd42);
      drive(1'b1, 2'b10, 6'b011000, 32'd7, 32'd6);
      @(negedge clk);
      valid_i = 1'b0;
      check("nomul_valid", {31'b0, valid2}, 32'd1);
      check("nomul_illegal", {31'b0, ill2}, 32'd1);
      check("nomul_data", data2, 32'h0);
      check("nomul_ready", {31'b0, ready2}, 32'd1);
      repeat (34) @(negedge clk);
      check("nomul_ready_never_dropped", {31'b0, dut2_ready_dropped}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage unit combining ALU control decode with the datapath and an iterative multiplier. It accepts one operation per handshake, decodes `ALUOp_i`/`funct_i`, and returns a registered result. Single-cycle ops complete in one cycle; multiply runs as a shift-add sequence that holds the issuing pipeline off via `ready_o`. It sits between ID/EX and EX/MEM and replaces the combinational ALU-control/ALU pair.

## Interface
- `DATA_W`, 32: operand and result width (≥ 4).
- `MUL_EN`, 1: 1 = multiply supported; 0 = multiply funct decodes as illegal.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous and active-high.
- `valid_i`  in  1  operation request.
- `kill_i`  in  1  synchronous abort of an in-flight multiply.
- `ALUOp_i`  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or.
- `funct_i`  in  6  R-type function code.
- `data1_i`  in  DATA_W  operand A (rs).
- `data2_i`  in  DATA_W  operand B (rt or immediate).
- `ready_o`  out  1  unit can accept an operation this cycle.
- `valid_o`  out  1  one-cycle pulse: `data_o`/`zero_o` are valid.
- `data_o`  out  DATA_W  result.
- `zero_o`  out  1  `data_o == 0`; meaningful only with `valid_o`.
- `illegal_o`  out  1  one-cycle pulse: accepted R-type funct not recognised.

## Operation
- Accept = `valid_i & ready_o` sampled on a rising edge. Operands and decode are captured at accept; later input changes are ignored.
- R-type funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 011000 mul.
- Unrecognised funct, or mul with `MUL_EN=0`: completes as a single-cycle op with `data_o=0`, `valid_o=1`, `illegal_o=1`.
- Arithmetic:
  - add/sub wrap modulo 2^DATA_W; no overflow flag.
  - slt is a signed two's-complement compare; the result is zero-extended 1/0.
  - mul returns the low DATA_W bits of the unsigned product. This equals the signed low half.
- FSM states: IDLE, MUL.
  - IDLE: `ready_o=1`. Accepting a non-mul op stays in IDLE. Accepting a mul loads the multiplicand and multiplier, clears the accumulator, sets the counter to DATA_W, and moves to MUL.
  - MUL: `ready_o=0`. On each edge, if multiplier bit 0 is set, add the multiplicand to the accumulator. Then shift the multiplicand left 1, shift the multiplier right 1, and decrement the counter. When the counter reaches 0 on an edge, go to IDLE and pulse `valid_o`.
  - Early termination is not allowed; latency is fixed.
- `kill_i` in MUL: go to IDLE on the next edge with no `valid_o`; the result is discarded. `kill_i` in IDLE has no effect; a same-cycle `valid_i` is still accepted.
- `data_o` holds its last value between `valid_o` pulses.

## Timing
- Reset values: state IDLE, `ready_o=1`, `valid_o=0`, `illegal_o=0`, `data_o=0`, `zero_o=1`, counter 0, accumulator 0.
- Single-cycle op accepted at edge k: `valid_o` high for exactly the cycle after edge k.
- Mul accepted at edge k:
  - `ready_o` low after edges k … k+DATA_W−1.
  - `valid_o` and `ready_o` both high after edge k+DATA_W. Latency is DATA_W cycles.
- Back-to-back: a new op can be accepted in the cycle `valid_o` is high, so there is no bubble.
- There is no output backpressure; the consumer must take the result in the `valid_o` cycle.
- `rst_i` asserted at any time, including mid-multiply, forces the reset values immediately (asynchronously). No `valid_o` is produced for the aborted operation.
- `kill_i` and the final iteration on the same edge: `kill_i` wins and there is no `valid_o`.

## Test plan
- Reset mid-multiply (DATA_W=32): accept mul, assert `rst_i` after 5 cycles → outputs take reset values immediately, `ready_o=1`, no `valid_o` ever appears. After release, add 2+3 → `data_o=5`.
- Single-cycle ops, DATA_W=32, back-to-back accepts:
  - add 0xFFFFFFFF+1 → `data_o=0`, `zero_o=1`.
  - sub 5−7 → `data_o=0xFFFFFFFE`.
  - and 0xF0F0 with 0xFF00 → `data_o=0xF000`.
  - slt with A=−1, B=1 → `data_o=1`.
  - Each result's `valid_o` appears 1 cycle after its accept.
- Multiply:
  - 7×6 → `ready_o` low 32 cycles; `data_o=42` with `valid_o` 32 cycles after accept.
  - 0xFFFFFFFF×2 → `data_o=0xFFFFFFFE`.
  - A new add issued in the `valid_o` cycle is accepted.
- Kill:
  - `kill_i` 10 cycles into a mul → IDLE next edge, no `valid_o`, `data_o` unchanged.
  - `kill_i` on the final iteration edge → no `valid_o`.
- Illegal:
  - R-type funct 111111 → `valid_o=1`, `illegal_o=1`, `data_o=0`.
  - With `MUL_EN=0`, funct 011000 → the same illegal response, and `ready_o` never drops.
